// File: rtl/edge_interval_checker.sv
// ---------------------------------------------------------------------------
// edge_interval_checker
//
// Measures the number of clk cycles from an event on the reference signal s1
// to the next event on the target signal s2. A violation is flagged when that
// interval is shorter than the programmable minimum lim. Typical uses are
// protocol timing checks such as I2C tHD;STA, tLOW, tHIGH and tSU;STO.
//
// Parameters
//   CNT_W  width of the interval counter, lim, last_delta and vio_cnt
//   EDGE1  event type on s1: 0 = any change, 1 = rising, 2 = falling
//          (3 behaves as any change)
//   EDGE2  event type on s2, same encoding as EDGE1
//
// Ports
//   clk        input   single clock, all logic on its rising edge
//   rst        input   synchronous active-low reset
//   s1         input   reference signal, already synchronous to clk
//   s2         input   target signal, already synchronous to clk
//   lim        input   minimum allowed interval in clk cycles (held stable)
//   vio        output  violation indication, one cycle after the s2 event
//   vio_cnt    output  saturating count of violations since reset
//   last_delta output  interval measured at the most recent s2 event
//   armed      output  an s1 event has been seen since reset
//
// Build option
//   CHECK_VIO_STICKY_EN  when defined, vio is set by the first violation and
//                        held until reset; otherwise vio is a one-cycle pulse
//                        per violation.
// ---------------------------------------------------------------------------
module edge_interval_checker #(
    parameter int CNT_W = 16,
    parameter int EDGE1 = 1,
    parameter int EDGE2 = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s1,
    input  logic             s2,
    input  logic [CNT_W-1:0] lim,
    output logic             vio,
    output logic [CNT_W-1:0] vio_cnt,
    output logic [CNT_W-1:0] last_delta,
    output logic             armed
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             s1_q;
    logic             s2_q;
    logic [CNT_W-1:0] cnt;
    logic             vio_q;

    logic             e1;
    logic             e2;
    logic [CNT_W-1:0] delta;
    logic             violation;

    function automatic logic sel_edge(input int mode, input logic x, input logic x_q);
        logic ev;
        case (mode)
            1:       ev = x & ~x_q;
            2:       ev = ~x & x_q;
            default: ev = x ^ x_q;
        endcase
        return ev;
    endfunction

    always_comb begin
        e1        = sel_edge(EDGE1, s1, s1_q);
        e2        = sel_edge(EDGE2, s2, s2_q);
        // A coincident s1 event restarts the interval, so it measures zero.
        delta     = e1 ? '0 : cnt;
        // Unsigned compare: lim == 0 can never be exceeded from below.
        violation = e2 & (armed | e1) & (delta < lim);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // Load the history with the current inputs so that releasing
            // reset never produces a spurious edge.
            s1_q       <= s1;
            s2_q       <= s2;
            cnt        <= '0;
            armed      <= 1'b0;
            last_delta <= '0;
            vio_cnt    <= '0;
            vio_q      <= 1'b0;
        end else begin
            s1_q <= s1;
            s2_q <= s2;

            if (e1) begin
                cnt   <= CNT_ONE;
                armed <= 1'b1;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_ONE;
            end

            if (e2) begin
                last_delta <= delta;
            end

            if (violation && (vio_cnt != CNT_MAX)) begin
                vio_cnt <= vio_cnt + CNT_ONE;
            end

`ifdef CHECK_VIO_STICKY_EN
            if (violation) begin
                vio_q <= 1'b1;
            end
`else
            vio_q <= violation;
`endif
        end
    end

    assign vio = vio_q;

endmodule

// File: tb/tb_edge_interval_checker.sv
// ---------------------------------------------------------------------------
// tb_edge_interval_checker
//
// Directed bench for edge_interval_checker. Three instances share s1/s2/rst:
//   u_rr   EDGE1=1 EDGE2=1 CNT_W=16  (rise -> rise)
//   u_ar   EDGE1=0 EDGE2=1 CNT_W=16  (any change -> rise)
//   u_sat  EDGE1=1 EDGE2=1 CNT_W=2   (exposes counter saturation)
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled there too, so every sample reflects the edge just taken.
// ---------------------------------------------------------------------------
module tb_edge_interval_checker;

`ifdef CHECK_VIO_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        s1;
    logic        s2;
    logic [15:0] lim;
    logic [1:0]  lim_c;

    logic        vio_a,   armed_a;
    logic [15:0] vcnt_a,  last_a;
    logic        vio_b,   armed_b;
    logic [15:0] vcnt_b,  last_b;
    logic        vio_c,   armed_c;
    logic [1:0]  vcnt_c,  last_c;

    int n_checks = 0;
    int n_errors = 0;

    edge_interval_checker #(.CNT_W(16), .EDGE1(1), .EDGE2(1)) u_rr (
        .clk(clk), .rst(rst), .s1(s1), .s2(s2), .lim(lim),
        .vio(vio_a), .vio_cnt(vcnt_a), .last_delta(last_a), .armed(armed_a)
    );

    edge_interval_checker #(.CNT_W(16), .EDGE1(0), .EDGE2(1)) u_ar (
        .clk(clk), .rst(rst), .s1(s1), .s2(s2), .lim(lim),
        .vio(vio_b), .vio_cnt(vcnt_b), .last_delta(last_b), .armed(armed_b)
    );

    edge_interval_checker #(.CNT_W(2), .EDGE1(1), .EDGE2(1)) u_sat (
        .clk(clk), .rst(rst), .s1(s1), .s2(s2), .lim(lim_c),
        .vio(vio_c), .vio_cnt(vcnt_c), .last_delta(last_c), .armed(armed_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst   = 1'b0;
        s1    = 1'b0;
        s2    = 1'b0;
        lim   = 16'd5;
        lim_c = 2'd3;

        // Reset state and basic rise->rise violation (delta 3 < 5)
        do_reset();
        chk("rst_vio",   32'(vio_a),   32'd0);
        chk("rst_vcnt",  32'(vcnt_a),  32'd0);
        chk("rst_last",  32'(last_a),  32'd0);
        chk("rst_armed", 32'(armed_a), 32'd0);
        ticks(4);
        s1 = 1'b1;
        ticks(3);
        s2 = 1'b1;
        tick();
        chk("t1_vio",   32'(vio_a),   32'd1);
        chk("t1_last",  32'(last_a),  32'd3);
        chk("t1_vcnt",  32'(vcnt_a),  32'd1);
        chk("t1_armed", 32'(armed_a), 32'd1);
        tick();
        chk("t1_vio_after", 32'(vio_a), 32'(STICKY));

        // Interval 8 >= 5: no violation
        s1 = 1'b0;
        s2 = 1'b0;
        do_reset();
        s1 = 1'b1;
        ticks(8);
        s2 = 1'b1;
        tick();
        chk("t2_last", 32'(last_a), 32'd8);
        chk("t2_vio",  32'(vio_a),  32'd0);
        chk("t2_vcnt", 32'(vcnt_a), 32'd0);
        tick();
        chk("t2_vio_late", 32'(vio_a), 32'd0);

        // s2 event before any s1 event is never a violation
        s1 = 1'b0;
        s2 = 1'b0;
        do_reset();
        tick();
        s2 = 1'b1;
        tick();
        chk("t3_armed", 32'(armed_a), 32'd0);
        chk("t3_last",  32'(last_a),  32'd1);
        chk("t3_vcnt",  32'(vcnt_a),  32'd0);
        tick();
        chk("t3_vio",   32'(vio_a),   32'd0);
        s2 = 1'b0;
        s1 = 1'b1;
        tick();
        chk("t3_armed_set", 32'(armed_a), 32'd1);

        // s1 falls, s2 rises 2 cycles later, lim 4
        s1  = 1'b1;
        s2  = 1'b0;
        lim = 16'd4;
        do_reset();
        s1 = 1'b0;
        ticks(2);
        s2 = 1'b1;
        tick();
        chk("t4_any_vio",   32'(vio_b),   32'd1);
        chk("t4_any_last",  32'(last_b),  32'd2);
        chk("t4_any_vcnt",  32'(vcnt_b),  32'd1);
        chk("t4_any_armed", 32'(armed_b), 32'd1);
        chk("t4_rise_vio",   32'(vio_a),   32'd0);
        chk("t4_rise_armed", 32'(armed_a), 32'd0);
        chk("t4_rise_vcnt",  32'(vcnt_a),  32'd0);

        // Simultaneous events give delta 0; lim 0 never flags
        s1  = 1'b0;
        s2  = 1'b0;
        lim = 16'd3;
        do_reset();
        tick();
        s1 = 1'b1;
        s2 = 1'b1;
        tick();
        chk("t5_vio",  32'(vio_a),  32'd1);
        chk("t5_last", 32'(last_a), 32'd0);
        chk("t5_vcnt", 32'(vcnt_a), 32'd1);
        lim = 16'd0;
        s1 = 1'b0;
        s2 = 1'b0;
        tick();
        s2 = 1'b1;
        tick();
        chk("t5_lim0_last", 32'(last_a), 32'd2);
        chk("t5_lim0_vcnt", 32'(vcnt_a), 32'd1);
        s2 = 1'b0;
        tick();
        s1 = 1'b1;
        s2 = 1'b1;
        tick();
        chk("t5_lim0_last2", 32'(last_a), 32'd0);
        chk("t5_lim0_vcnt2", 32'(vcnt_a), 32'd1);
        chk("t5_lim0_vio",   32'(vio_a),  32'(STICKY));

        // Two violations after one s1 event, then a one-cycle reset
        s1  = 1'b0;
        s2  = 1'b0;
        lim = 16'd5;
        do_reset();
        s1 = 1'b1;
        tick();
        s2 = 1'b1;
        tick();
        chk("t6_vio1",  32'(vio_a),  32'd1);
        chk("t6_vcnt1", 32'(vcnt_a), 32'd1);
        chk("t6_last1", 32'(last_a), 32'd1);
        s2 = 1'b0;
        tick();
        chk("t6_vio_gap", 32'(vio_a), 32'(STICKY));
        s2 = 1'b1;
        tick();
        chk("t6_vio2",  32'(vio_a),  32'd1);
        chk("t6_vcnt2", 32'(vcnt_a), 32'd2);
        chk("t6_last2", 32'(last_a), 32'd3);
        tick();
        chk("t6_vio_hold", 32'(vio_a), 32'(STICKY));
        rst = 1'b0;
        tick();
        chk("t6_rst_vio",   32'(vio_a),   32'd0);
        chk("t6_rst_vcnt",  32'(vcnt_a),  32'd0);
        chk("t6_rst_last",  32'(last_a),  32'd0);
        chk("t6_rst_armed", 32'(armed_a), 32'd0);
        rst = 1'b1;
        tick();
        chk("t6_rel_armed", 32'(armed_a), 32'd0);

        // Narrow instance: interval counter and vio_cnt saturate at 3
        s1 = 1'b0;
        s2 = 1'b0;
        do_reset();
        s1 = 1'b1;
        ticks(7);
        s2 = 1'b1;
        tick();
        chk("t7_sat_last", 32'(last_c), 32'd3);
        chk("t7_sat_vcnt", 32'(vcnt_c), 32'd0);
        s1 = 1'b0;
        s2 = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            s1 = 1'b1;
            s2 = 1'b1;
            tick();
            s1 = 1'b0;
            s2 = 1'b0;
            tick();
        end
        chk("t7_vcnt_sat", 32'(vcnt_c), 32'd3);
        chk("t7_last0",    32'(last_c), 32'd0);
        chk("t7_vcnt_a",   32'(vcnt_a), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
